display_scan_controller: RTL and testbench
==========================================

# display_scan_controller

Parametrised multi-digit seven-segment driver that generalises the single-digit display path. It accepts a binary result through a load handshake and converts it to BCD sequentially with iterative double-dabble (one shift per clock). It then time-multiplexes NUM_DIGITS digits onto one shared segment bus with per-digit anode enables, leading-zero blanking, overflow indication and selectable output polarity. It sits between the result register of the datapath and the board's seven-segment pins.

## Interface
- DATA_W, 32, width of input value (≥4)
- NUM_DIGITS, 4, number of physical digits scanned (1..8)
- REFRESH_DIV, 50000, clock cycles each digit stays enabled (≥1)
- BLANK_LEADING, 1, 1 = blank leading zeros (digit 0 always shown)
- SEG_ACTIVE_LOW, 0, 1 = invert seg and an at the outputs
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- load  in  1  request to convert value; accepted only when busy=0
- value  in  DATA_W  unsigned binary to display; sampled on accepted load
- busy  out  1  conversion in progress; load ignored while high
- done  out  1  one-cycle pulse when new digits are committed to display
- overflow  out  1  last committed value ≥ 10^NUM_DIGITS
- seg  out  7  segment pattern, bit order {g,f,e,d,c,b,a}
- an  out  NUM_DIGITS  one-hot digit enable, bit 0 = rightmost digit

## Operation
- Converter FSM: IDLE → SHIFT → DONE → IDLE.
- IDLE:
  - load=1 captures value into the shift register.
  - Clears the BCD accumulator (BCD_DIGITS = decimal digit count of 2^DATA_W−1).
  - Loads bit counter = DATA_W and moves to SHIFT.
- SHIFT, each cycle:
  - Every BCD nibble ≥5 gets +3.
  - {bcd, bin} then shifts left by 1.
  - Counter decrements; the cycle the counter hits 0 moves to DONE.
- DONE:
  - Commits the low NUM_DIGITS nibbles to the display digit register.
  - overflow = any higher nibble nonzero.
  - done=1 for this cycle; returns to IDLE.
- Display register changes only in DONE, so scanning never shows partial results.
- Scan: refresh counter counts 0..REFRESH_DIV−1. At terminal count it wraps to 0 and the digit index advances 0→1→…→NUM_DIGITS−1→0.
- Per-digit segment pattern, in priority order:
  - overflow=1 → '-' (7'h40) on every digit.
  - Else blanked leading zero → 7'h00. A digit is blanked if BLANK_LEADING=1, its index >0, and it and all higher digits are 0.
  - Else standard decode: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
- an = one-hot of the digit index. Blanked digits keep their anode slot with seg=0, so scan period is constant.
- SEG_ACTIVE_LOW=1 inverts seg and an after all logic. Reset values are inverted likewise.

## Timing
- Reset (while rst=1):
  - FSM=IDLE, busy=0, done=0, overflow=0.
  - Display register=0, refresh counter=0, digit index=0.
  - seg=7'h00, an=0 (all dark, pre-inversion).
- First cycle after rst falls: an=0001, seg=3F (shows "0").
- Load latency:
  - load accepted at edge N.
  - busy=1 from N+1 through the DONE cycle.
  - done=1 in cycle N+DATA_W+1. New digits appear on seg/an from N+DATA_W+2.
- busy returns 0 the cycle after done. A load in the same cycle done is high is ignored; earliest accepted load is in the cycle after done.
- seg/an are registered. They change only when the digit index changes, at refresh wrap or at a display commit.
- A commit does not reset the scan position.
- rst mid-conversion aborts: no done pulse, display returns to 0.
- REFRESH_DIV=1: digit advances every cycle.

## Structure
- Package display_pkg:
  - function bcd_digits(width): decimal digits of 2^width−1.
  - localparam-style 7-segment constants (digits 0-9, SEG_DASH, SEG_BLANK).
  - FSM state typedef enum {IDLE, SHIFT, DONE}.
- One sub-module, seq_binary_to_bcd, holds the FSM, shift register, add-3 logic and handshake, and outputs the BCD vector plus done.
- Top holds the display register, overflow flag, blanking, refresh counter, digit mux, decode and polarity stage.

## Test plan
Bench parameters: DATA_W=16, NUM_DIGITS=4, REFRESH_DIV=4, BLANK_LEADING=1.
- Reset: hold rst 3 cycles → seg=00, an=0000, busy=0. Release → an=0001 seg=3F. Digits 1-3 show seg=00 on an=0010, 0100, 1000, each for 4 cycles.
- Load 1234 → busy 16+1 cycles, done pulse at N+17. Scan then gives an=0001/66, 0010/4F, 0100/5B, 1000/06, overflow=0.
- Load 7 → an=0001/07, other digits 00. Load 9999 → all four 6F.
- Load 10000, then 65535 → overflow=1, all digits 40. Load 5 afterwards → overflow=0, digit0=6D.
- Pulse load=4321 mid-conversion of 1234 → ignored, result 1234. rst at shift 8 → no done, display 0, a new load converts correctly.
- SEG_ACTIVE_LOW=1 rerun of the 1234 case → seg/an exact bitwise complements, reset drives seg=7F and an=1111.

Source files
------------

// File: rtl/display_scan_controller_pkg.sv
// Shared constants, FSM state type and helpers for the seven-segment scan controller.
// Pure declarations: no logic, no latency, no flow control.
package display_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_e;

  // floor(width*log10(2))+1; 2^width is never a power of ten, so this counts digits of 2^width-1
  function automatic int bcd_digits(input int width);
    return (width * 30103) / 100000 + 1;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// Load handshake plus display pins between the datapath (master) and the scan controller (slave).
// Pure wiring: no latency; load is only honoured while busy is low.
interface display_scan_controller_if #(
  parameter int DATA_W     = 32,
  parameter int NUM_DIGITS = 4
);
  logic                  load;
  logic [DATA_W-1:0]     value;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] an;

  modport master (output load, value, input busy, done, overflow, seg, an);
  modport slave  (input load, value, output busy, done, overflow, seg, an);
endinterface

// File: rtl/display_scan_controller_seq_binary_to_bcd.sv
// Iterative double-dabble converter, one shift per clock; done pulses DATA_W+1 cycles after an accepted load.
// load is dropped, not queued, whenever the FSM is not IDLE (busy high).
module seq_binary_to_bcd
  import display_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int BCD_DIGITS = bcd_digits(DATA_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [DATA_W-1:0]       value_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [4*BCD_DIGITS-1:0] bcd_o
);

  localparam int BW = 4 * BCD_DIGITS;
  localparam int CW = $clog2(DATA_W + 1);

  conv_state_e       state_q;
  logic [DATA_W-1:0] bin_q;
  logic [BW-1:0]     bcd_q;
  logic [BW-1:0]     bcd_adj;
  logic [CW-1:0]     cnt_q;
  logic              busy_q;
  logic              done_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_i) begin
            bin_q   <= value_i;
            bcd_q   <= '0;
            cnt_q   <= CW'(DATA_W);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= {bcd_adj[BW-2:0], bin_q[DATA_W-1]};
          bin_q <= {bin_q[DATA_W-2:0], 1'b0};
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/display_scan_controller.sv
// Multi-digit seven-segment scanner: converts loaded values to BCD, then multiplexes digits onto a shared bus.
// New digits reach seg/an DATA_W+2 cycles after load; loads while busy are dropped.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_LEADING  = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input logic                       clk,
  input logic                       rst,
  display_scan_controller_if.slave  bus
);

  localparam int BCD_DIGITS = bcd_digits(DATA_W);
  localparam int EXT_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
  localparam int EXT_W      = 4 * EXT_DIGITS;
  localparam int DW         = 4 * NUM_DIGITS;
  localparam int RW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    conv_busy;
  logic                    conv_done;
  logic [4*BCD_DIGITS-1:0] conv_bcd;
  logic [EXT_W-1:0]        bcd_ext;
  logic                    conv_ovf;

  logic [DW-1:0]           disp_q, disp_d;
  logic                    ovf_q, ovf_d;
  logic [RW-1:0]           ref_q, ref_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    wrap;
  logic                    upper_zero;
  logic [3:0]              cur_nib;

  seq_binary_to_bcd #(
    .DATA_W     (DATA_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_conv (
    .clk     (clk),
    .rst     (rst),
    .load_i  (bus.load),
    .value_i (bus.value),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  assign bcd_ext = EXT_W'(conv_bcd);

  // Anything in the nibbles above the visible digits means the value does not fit
  if (EXT_DIGITS > NUM_DIGITS) begin : g_ovf
    assign conv_ovf = |bcd_ext[EXT_W-1:DW];
  end else begin : g_no_ovf
    assign conv_ovf = 1'b0;
  end

  assign disp_d = conv_done ? bcd_ext[DW-1:0] : disp_q;
  assign ovf_d  = conv_done ? conv_ovf : ovf_q;

  assign wrap  = (ref_q == RW'(REFRESH_DIV - 1));
  assign ref_d = wrap ? '0 : ref_q + RW'(1);
  assign idx_d = !wrap                       ? idx_q :
                 (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);

  // Decode from next-state values so a commit or index step lands on the pins at the same edge
  always_comb begin
    upper_zero = 1'b1;
    cur_nib    = 4'd0;
    an_d       = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx_d) begin
        cur_nib = disp_d[4*i +: 4];
        an_d[i] = 1'b1;
      end
      if (IW'(i) >= idx_d && disp_d[4*i +: 4] != 4'd0) upper_zero = 1'b0;
    end
    if (ovf_d)
      seg_d = SEG_DASH;
    else if (BLANK_LEADING != 0 && idx_d != '0 && upper_zero)
      seg_d = SEG_BLANK;
    else
      seg_d = seg_decode(cur_nib);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= '0;
      ovf_q  <= 1'b0;
      ref_q  <= '0;
      idx_q  <= '0;
      seg_q  <= SEG_BLANK;
      an_q   <= '0;
    end else begin
      disp_q <= disp_d;
      ovf_q  <= ovf_d;
      ref_q  <= ref_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign bus.busy     = conv_busy;
  assign bus.done     = conv_done;
  assign bus.overflow = ovf_q;
  assign bus.seg      = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign bus.an       = (SEG_ACTIVE_LOW != 0) ? ~an_q : an_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench: an active-high and an active-low instance run side by side on the same stimulus.
module tb_display_scan_controller;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  display_scan_controller_if #(.DATA_W(16), .NUM_DIGITS(4)) bus ();
  display_scan_controller_if #(.DATA_W(16), .NUM_DIGITS(4)) bus_n ();

  assign bus_n.load  = bus.load;
  assign bus_n.value = bus.value;

  display_scan_controller #(
    .DATA_W(16), .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LEADING(1), .SEG_ACTIVE_LOW(0)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  display_scan_controller #(
    .DATA_W(16), .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LEADING(1), .SEG_ACTIVE_LOW(1)
  ) dut_n (.clk(clk), .rst(rst), .bus(bus_n));

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0][6:0] seg;   // [3] = leftmost digit
    logic            ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Load a value and verify the busy window and the single done pulse
  task automatic do_load(input logic [15:0] v);
    int busy_cnt;
    int done_at;
    int done_cnt;
    @(negedge clk);
    bus.load  = 1'b1;
    bus.value = v;
    @(negedge clk);
    bus.load  = 1'b0;
    busy_cnt = 0;
    done_at  = -1;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      @(negedge clk);
    end
    chk("busy_cycles", busy_cnt, 17);
    chk("done_cycle", done_at, 16);
    chk("done_pulses", done_cnt, 1);
  endtask

  // Align to the start of a digit-0 window, then check each digit on both polarities
  task automatic check_scan(input logic [3:0][6:0] exp, input logic exp_ovf);
    logic [3:0] prev;
    logic [6:0] inv_seg;
    logic [3:0] inv_an;
    logic [3:0] onehot;
    bit         found;
    found = 1'b0;
    prev  = bus.an;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.an == 4'b0001 && prev != 4'b0001) found = 1'b1;
      prev = bus.an;
    end
    chk("scan_align", found, 1);
    chk("overflow", bus.overflow, exp_ovf);
    for (int k = 0; k < 4; k++) begin
      onehot  = 4'b0001 << k;
      inv_seg = ~exp[k];
      inv_an  = ~onehot;
      chk("scan_an", bus.an, onehot);
      chk("scan_seg", bus.seg, exp[k]);
      chk("inv_an", bus_n.an, inv_an);
      chk("inv_seg", bus_n.seg, inv_seg);
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    int         idx;
    int         done_seen;
    bit         got_done;
    logic [3:0] onehot;

    vecs[0] = '{16'd1234,  {7'h06, 7'h5B, 7'h4F, 7'h66}, 1'b0};
    vecs[1] = '{16'd7,     {7'h00, 7'h00, 7'h00, 7'h07}, 1'b0};
    vecs[2] = '{16'd9999,  {7'h6F, 7'h6F, 7'h6F, 7'h6F}, 1'b0};
    vecs[3] = '{16'd10000, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b1};
    vecs[4] = '{16'd65535, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b1};
    vecs[5] = '{16'd5,     {7'h00, 7'h00, 7'h00, 7'h6D}, 1'b0};
    vecs[6] = '{16'd1000,  {7'h06, 7'h3F, 7'h3F, 7'h3F}, 1'b0};
    vecs[7] = '{16'd305,   {7'h00, 7'h4F, 7'h3F, 7'h6D}, 1'b0};
    vecs[8] = '{16'd0,     {7'h00, 7'h00, 7'h00, 7'h3F}, 1'b0};

    rst       = 1'b1;
    bus.load  = 1'b0;
    bus.value = '0;
    repeat (3) @(negedge clk);
    chk("rst_seg", bus.seg, 7'h00);
    chk("rst_an", bus.an, 4'b0000);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_ovf", bus.overflow, 1'b0);
    chk("rst_inv_seg", bus_n.seg, 7'h7F);
    chk("rst_inv_an", bus_n.an, 4'b1111);

    // First pass after release: digit 0 for 3 cycles, then 4 cycles per digit
    rst = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      idx    = (c < 4) ? 0 : c / 4;
      onehot = 4'b0001 << idx;
      chk("rel_an", bus.an, onehot);
      chk("rel_seg", bus.seg, (idx == 0) ? 7'h3F : 7'h00);
    end

    for (int v = 0; v < 9; v++) begin
      do_load(vecs[v].value);
      check_scan(vecs[v].seg, vecs[v].ovf);
    end

    // Loads during SHIFT and during the DONE cycle are both dropped
    @(negedge clk);
    bus.load  = 1'b1;
    bus.value = 16'd1234;
    @(negedge clk);
    bus.load  = 1'b0;
    repeat (5) @(negedge clk);
    bus.load  = 1'b1;
    bus.value = 16'd4321;
    @(negedge clk);
    bus.load  = 1'b0;
    got_done  = 1'b0;
    for (int i = 0; i < 30 && !got_done; i++) begin
      if (bus.done) got_done = 1'b1;
      else @(negedge clk);
    end
    chk("ign_done_seen", got_done, 1);
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    chk("ign_busy_after_done", bus.busy, 1'b0);
    @(negedge clk);
    chk("ign_busy_later", bus.busy, 1'b0);
    check_scan(vecs[0].seg, 1'b0);

    // Reset partway through the shifts aborts with no done and clears the display
    @(negedge clk);
    bus.load  = 1'b1;
    bus.value = 16'd9876;
    @(negedge clk);
    bus.load  = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done) done_seen++;
      @(negedge clk);
    end
    chk("abort_done", done_seen, 0);
    chk("abort_busy", bus.busy, 1'b0);
    check_scan({7'h00, 7'h00, 7'h00, 7'h3F}, 1'b0);
    do_load(16'd42);
    check_scan({7'h00, 7'h00, 7'h66, 7'h5B}, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
